// File: rtl/trainled_node.sv
// Daisy-chainable TrainLED node: decodes a pulse-width serial stream, keeps NLEDS duties, forwards the rest.
// Optional gamma correction of latched duties is enabled by defining TRAINLED_GAMMA_EN.
`timescale 1ns/1ps

module trainled_node #(
  parameter int NLEDS    = 3,
  parameter int PWM_BITS = 4,
  parameter int T_SAMPLE = 3,
  parameter int T_IDLE   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic             dout,
  output logic [NLEDS-1:0] led,
  output logic             frame_strobe
);

  localparam int NBITS = NLEDS * PWM_BITS;
  localparam int BC_W  = $clog2(NBITS + 1);
  localparam int LC_W  = $clog2(T_IDLE + 1);
  localparam int SC_W  = $clog2(T_SAMPLE + 1);

  localparam logic [1:0] ST_CONSUME = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_PASS    = 2'd2;

  localparam logic [BC_W-1:0]     BC_FULL  = BC_W'(NBITS);
  localparam logic [LC_W-1:0]     LC_IDLE  = LC_W'(T_IDLE);
  localparam logic [SC_W-1:0]     SC_FIRE  = SC_W'(T_SAMPLE);
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

`ifdef TRAINLED_GAMMA_EN
  // (d+1)^2 wraps to 0 for d = max, so subtracting 1 still yields all ones there.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] dp1;
    logic [2*PWM_BITS-1:0] sq;
    dp1 = (2*PWM_BITS)'(d) + (2*PWM_BITS)'(1);
    sq  = dp1 * dp1;
    return PWM_BITS'((sq - (2*PWM_BITS)'(1)) >> PWM_BITS);
  endfunction
`endif

  logic [1:0]                     rst_sync_q, rst_sync_d;
  logic                           rst_n;
  logic                           sync1_q, sync1_d;
  logic                           din_s_q, din_s_d;
  logic                           din_prev_q, din_prev_d;
  logic [LC_W-1:0]                low_cnt_q, low_cnt_d;
  logic [SC_W-1:0]                samp_cnt_q, samp_cnt_d;
  logic                           samp_act_q, samp_act_d;
  logic [NBITS-1:0]               sr_q, sr_d;
  logic [BC_W-1:0]                bitcnt_q, bitcnt_d;
  logic [1:0]                     state_q, state_d;
  logic [NLEDS-1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0]            pwm_cnt_q, pwm_cnt_d;
  logic [NLEDS-1:0]               led_q, led_d;
  logic                           strobe_q, strobe_d;

  logic rise, sample_fire, eof, full;

  // The pin reset asserts asynchronously but is released only on a clock edge.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  assign rise        = din_s_q & ~din_prev_q;
  assign sample_fire = samp_act_q && (samp_cnt_q == SC_FIRE);
  assign eof         = !din_s_q && (low_cnt_q == LC_IDLE - LC_W'(1));
  assign full        = (bitcnt_q == BC_FULL);

  always_comb begin
    sync1_d    = din;
    din_s_d    = sync1_q;
    din_prev_d = din_s_q;

    low_cnt_d = low_cnt_q;
    if (din_s_q)                 low_cnt_d = '0;
    else if (low_cnt_q != LC_IDLE) low_cnt_d = low_cnt_q + LC_W'(1);

    samp_cnt_d = samp_cnt_q;
    samp_act_d = samp_act_q;
    if (rise) begin
      samp_cnt_d = SC_W'(1);
      samp_act_d = 1'b1;
    end else if (sample_fire) begin
      samp_act_d = 1'b0;
    end else if (samp_act_q) begin
      samp_cnt_d = samp_cnt_q + SC_W'(1);
    end
  end

  // Frame FSM; EOF overrides whatever state the node is in.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    duty_d   = duty_q;
    strobe_d = 1'b0;
    if (eof) begin
      bitcnt_d = '0;
      state_d  = ST_CONSUME;
      if (full) begin
        strobe_d = 1'b1;
        for (int i = 0; i < NLEDS; i++) begin
`ifdef TRAINLED_GAMMA_EN
          duty_d[i] = gamma_map(sr_q[NBITS-1-i*PWM_BITS -: PWM_BITS]);
`else
          duty_d[i] = sr_q[NBITS-1-i*PWM_BITS -: PWM_BITS];
`endif
        end
      end
    end else begin
      case (state_q)
        ST_CONSUME: begin
          if (sample_fire) begin
            sr_d     = {sr_q[NBITS-2:0], din_s_q};
            bitcnt_d = bitcnt_q + BC_W'(1);
            if (bitcnt_q == BC_FULL - BC_W'(1)) state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (!din_s_q) state_d = ST_PASS;
        end
        ST_PASS: begin
          state_d = ST_PASS;
        end
        default: state_d = ST_CONSUME;
      endcase
    end
  end

  // Period is 2^PWM_BITS-1 so a full-scale duty stays on continuously.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    for (int i = 0; i < NLEDS; i++) begin
      led_d[i] = (pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      din_s_q    <= 1'b0;
      din_prev_q <= 1'b0;
      low_cnt_q  <= LC_IDLE;
      samp_cnt_q <= '0;
      samp_act_q <= 1'b0;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      state_q    <= ST_CONSUME;
      duty_q     <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      strobe_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      din_s_q    <= din_s_d;
      din_prev_q <= din_prev_d;
      low_cnt_q  <= low_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      samp_act_q <= samp_act_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      state_q    <= state_d;
      duty_q     <= duty_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      strobe_q   <= strobe_d;
    end
  end

  assign dout         = (state_q == ST_PASS) & din_s_q;
  assign led          = led_q;
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_trainled_node.sv
// Table-driven bench for trainled_node: frames, forwarding, partial frames, mid-frame reset, gamma build.
`timescale 1ns/1ps

module tb_trainled_node;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       dout;
  logic [2:0] led;
  logic       frame_strobe;

  trainled_node dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .dout         (dout),
    .led          (led),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

`ifdef TRAINLED_GAMMA_EN
  localparam int G1 = 0, G2 = 0, G3 = 0, G8 = 5, GA = 7;
`else
  localparam int G1 = 1, G2 = 2, G3 = 3, G8 = 8, GA = 10;
`endif

  typedef struct {
    string       name;
    int          nbits;
    logic [23:0] bits;
    int          exp_strobe;
    int          exp_hi0;
    int          exp_hi1;
    int          exp_hi2;
  } vec_t;

  vec_t vecs[7];

  int   tests_run = 0;
  int   tests_failed = 0;
  int   strobe_cnt;
  int   dout_err;
  int   hi[3];
  logic d1, d2, f1, f2;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive the next din value.
  task automatic drive_cycle(input logic v, input logic pass_flag);
    @(negedge clk);
    if (dout !== (f2 ? d2 : 1'b0)) dout_err++;
    if (frame_strobe !== 1'b0) strobe_cnt++;
    d2  = d1;
    f2  = f1;
    d1  = v;
    f1  = pass_flag;
    din = v;
  endtask

  task automatic send_bit(input logic b, input logic pass_flag);
    for (int i = 0; i < 8; i++) drive_cycle(i < (b ? 6 : 1), pass_flag);
  endtask

  task automatic measure_leds();
    foreach (hi[j]) hi[j] = 0;
    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b0, 1'b0);
      for (int j = 0; j < 3; j++) hi[j] += int'(led[j]);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    strobe_cnt = 0;
    dout_err   = 0;
    d1 = 1'b0; d2 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    for (int k = 0; k < v.nbits; k++) send_bit(v.bits[v.nbits-1-k], k >= 12);
    for (int i = 0; i < 24; i++) drive_cycle(1'b0, 1'b0);
    measure_leds();
    checkOutput({v.name, "/strobe"}, strobe_cnt, v.exp_strobe);
    checkOutput({v.name, "/led0_hi"}, hi[0], v.exp_hi0);
    checkOutput({v.name, "/led1_hi"}, hi[1], v.exp_hi1);
    checkOutput({v.name, "/led2_hi"}, hi[2], v.exp_hi2);
    checkOutput({v.name, "/dout_err"}, dout_err, 0);
  endtask

  initial begin
    int bad;
    vecs[0] = '{"f80",      12, 24'h000F80, 1, 15, G8, 0};
    vecs[1] = '{"f80_3c5",  24, 24'hF803C5, 1, 15, G8, 0};
    vecs[2] = '{"partial7",  7, 24'h00005A, 0, 15, G8, 0};
    vecs[3] = '{"f123",     12, 24'h000123, 1, G1, G2, G3};
    vecs[4] = '{"fff",      12, 24'h000FFF, 1, 15, 15, 15};
    vecs[5] = '{"aaa",      12, 24'h000AAA, 1, GA, GA, GA};
    vecs[6] = '{"f8f0",     12, 24'h0008F0, 1, G8, 15, 0};

    d1 = 1'b0; d2 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    rst = 1'b0;
    din = 1'b0;

    // Reset with din toggling, then 20 quiet clocks after release.
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (led !== 3'b000 || dout !== 1'b0 || frame_strobe !== 1'b0) bad++;
      din = ~din;
    end
    @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (led !== 3'b000 || dout !== 1'b0 || frame_strobe !== 1'b0) bad++;
    end
    checkOutput("reset_quiet", bad, 0);

    for (int v = 0; v < 5; v++) applyStimulus(vecs[v]);

    // Mid-frame asynchronous reset while all LEDs are on.
    dout_err = 0;
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    checkOutput("pre_reset_led", int'(led), 7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_led", int'(led), 0);
    checkOutput("async_reset_dout_strobe", int'({dout, frame_strobe}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    din = 1'b0;
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0);
    measure_leds();
    checkOutput("post_reset_duty", hi[0] + hi[1] + hi[2], 0);

    applyStimulus(vecs[5]);
    applyStimulus(vecs[6]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
